// File: rtl/fft8_ctrl.sv
// Control sequencer for an 8-point radix-2 DIT FFT: bit-reversed load, 3x4 butterfly
// schedule with post-stage bubbles, natural-order drain. Holds no sample data.
module fft8_ctrl #(
    parameter int BF_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       load_en,
    output logic [2:0] load_addr,
    output logic       bf_en,
    output logic [1:0] stage,
    output logic [2:0] addr_a,
    output logic [2:0] addr_b,
    output logic [1:0] tw_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_addr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CALC  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_INIT = (BF_LAT > 0) ? 3'(BF_LAT - 1) : 3'd0;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] k_q, k_d;
    logic [1:0] stage_q, stage_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic       done_q, done_d;

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= 3'd0;
            k_q     <= 2'd0;
            stage_q <= 2'd0;
            wcnt_q  <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            wcnt_q  <= wcnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; k and stage freeze outside CALC so addresses hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        stage_d = stage_q;
        wcnt_d  = wcnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == 3'd7) begin
                        state_d = ST_CALC;
                        cnt_d   = 3'd0;
                        k_d     = 2'd0;
                        stage_d = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_CALC: begin
                if (k_q == 2'd3) begin
                    if (BF_LAT > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_INIT;
                    end else if (stage_q != 2'd2) begin
                        stage_d = stage_q + 2'd1;
                        k_d     = 2'd0;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 3'd0) begin
                    if (stage_q != 2'd2) begin
                        state_d = ST_CALC;
                        stage_d = stage_q + 2'd1;
                        k_d     = 2'd0;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == 3'd7) begin
                        state_d = ST_LOAD;
                        cnt_d   = 3'd0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Butterfly address and twiddle decode from (stage, k).
    always_comb begin
        addr_a = 3'd0;
        addr_b = 3'd1;
        tw_idx = 2'd0;
        case (stage_q)
            2'd0: begin
                addr_a = {k_q, 1'b0};
                addr_b = {k_q, 1'b1};
                tw_idx = 2'd0;
            end
            2'd1: begin
                addr_a = {k_q[1], 1'b0, k_q[0]};
                addr_b = {k_q[1], 1'b1, k_q[0]};
                tw_idx = {k_q[0], 1'b0};
            end
            2'd2: begin
                addr_a = {1'b0, k_q};
                addr_b = {1'b1, k_q};
                tw_idx = k_q;
            end
            default: begin
                addr_a = 3'd0;
                addr_b = 3'd1;
                tw_idx = 2'd0;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign load_en   = in_valid & in_ready;
    assign load_addr = bitrev3(cnt_q);
    assign bf_en     = (state_q == ST_CALC);
    assign stage     = stage_q;
    assign out_valid = (state_q == ST_DRAIN);
    assign out_addr  = cnt_q;
    assign busy      = !((state_q == ST_LOAD) && (cnt_q == 3'd0));
    assign done      = done_q;

endmodule

// File: tb/tb_fft8_ctrl.sv
// Directed bench for fft8_ctrl: one instance with BF_LAT=1 and one with BF_LAT=0,
// selected onto a shared set of observation signals.
module tb_fft8_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iv = 1'b0;
    logic ordy = 1'b0;
    logic sel0 = 1'b0;

    int compared = 0;
    int mismatched = 0;

    int brt[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int ea[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int eb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int et[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    logic       iv1, iv0, or1, or0;
    logic       in_ready1, load_en1, bf_en1, out_valid1, busy1, done1;
    logic       in_ready0, load_en0, bf_en0, out_valid0, busy0, done0;
    logic [2:0] load_addr1, addr_a1, addr_b1, out_addr1;
    logic [2:0] load_addr0, addr_a0, addr_b0, out_addr0;
    logic [1:0] stage1, tw_idx1, stage0, tw_idx0;

    logic       o_in_ready, o_load_en, o_bf_en, o_out_valid, o_busy, o_done;
    logic [2:0] o_load_addr, o_addr_a, o_addr_b, o_out_addr;
    logic [1:0] o_stage, o_tw_idx;

    assign iv1 = iv & !sel0;
    assign iv0 = iv & sel0;
    assign or1 = ordy & !sel0;
    assign or0 = ordy & sel0;

    always #5 clk = ~clk;

    fft8_ctrl #(.BF_LAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(in_ready1), .load_en(load_en1),
        .load_addr(load_addr1), .bf_en(bf_en1), .stage(stage1), .addr_a(addr_a1),
        .addr_b(addr_b1), .tw_idx(tw_idx1), .out_valid(out_valid1), .out_ready(or1),
        .out_addr(out_addr1), .busy(busy1), .done(done1)
    );

    fft8_ctrl #(.BF_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(in_ready0), .load_en(load_en0),
        .load_addr(load_addr0), .bf_en(bf_en0), .stage(stage0), .addr_a(addr_a0),
        .addr_b(addr_b0), .tw_idx(tw_idx0), .out_valid(out_valid0), .out_ready(or0),
        .out_addr(out_addr0), .busy(busy0), .done(done0)
    );

    always_comb begin
        o_in_ready  = sel0 ? in_ready0  : in_ready1;
        o_load_en   = sel0 ? load_en0   : load_en1;
        o_bf_en     = sel0 ? bf_en0     : bf_en1;
        o_out_valid = sel0 ? out_valid0 : out_valid1;
        o_busy      = sel0 ? busy0      : busy1;
        o_done      = sel0 ? done0      : done1;
        o_load_addr = sel0 ? load_addr0 : load_addr1;
        o_addr_a    = sel0 ? addr_a0    : addr_a1;
        o_addr_b    = sel0 ? addr_b0    : addr_b1;
        o_out_addr  = sel0 ? out_addr0  : out_addr1;
        o_stage     = sel0 ? stage0     : stage1;
        o_tw_idx    = sel0 ? tw_idx0    : tw_idx1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts in the current cycle; returns in the cycle of the 8th accept.
    task automatic load_frame(input logic [7:0] pat);
        int n = 0;
        int j = 0;
        while (n < 8 && j < 64) begin
            iv = pat[j % 8];
            ordy = 1'b1;
            #1;
            chk("in_ready_load", 32'(o_in_ready), 32'd1);
            chk("load_en", 32'(o_load_en), 32'(iv));
            chk("load_addr", 32'(o_load_addr), 32'(brt[n]));
            chk("busy_load", 32'(o_busy), (n != 0) ? 32'd1 : 32'd0);
            chk("done_load", 32'(o_done), 32'd0);
            chk("out_valid_load", 32'(o_out_valid), 32'd0);
            if (iv) n++;
            j++;
            if (n < 8) next_cycle();
        end
        chk("load_beats", 32'(n), 32'd8);
    endtask

    task automatic check_sched(input int lat);
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                next_cycle();
                iv = 1'b1;
                #1;
                chk("bf_en", 32'(o_bf_en), 32'd1);
                chk("stage", 32'(o_stage), 32'(s));
                chk("addr_a", 32'(o_addr_a), 32'(ea[s*4+k]));
                chk("addr_b", 32'(o_addr_b), 32'(eb[s*4+k]));
                chk("tw_idx", 32'(o_tw_idx), 32'(et[s*4+k]));
                chk("in_ready_calc", 32'(o_in_ready), 32'd0);
                chk("load_en_calc", 32'(o_load_en), 32'd0);
                chk("out_valid_calc", 32'(o_out_valid), 32'd0);
            end
            for (int l = 0; l < lat; l++) begin
                next_cycle();
                iv = 1'b1;
                #1;
                chk("bubble_bf_en", 32'(o_bf_en), 32'd0);
                chk("bubble_out_valid", 32'(o_out_valid), 32'd0);
                chk("bubble_addr_a", 32'(o_addr_a), 32'(ea[s*4+3]));
                chk("bubble_addr_b", 32'(o_addr_b), 32'(eb[s*4+3]));
                chk("bubble_load_en", 32'(o_load_en), 32'd0);
            end
        end
    endtask

    // Returns in the done cycle.
    task automatic drain(input logic [2:0] pat);
        int n = 0;
        int j = 0;
        while (n < 8 && j < 48) begin
            next_cycle();
            iv = 1'b1;
            ordy = pat[j % 3];
            #1;
            chk("out_valid", 32'(o_out_valid), 32'd1);
            chk("out_addr", 32'(o_out_addr), 32'(n));
            chk("done_drain", 32'(o_done), 32'd0);
            chk("load_en_drain", 32'(o_load_en), 32'd0);
            chk("busy_drain", 32'(o_busy), 32'd1);
            chk("bf_en_drain", 32'(o_bf_en), 32'd0);
            if (ordy) n++;
            j++;
        end
        chk("drain_beats", 32'(n), 32'd8);
        next_cycle();
        iv = 1'b0;
        ordy = 1'b0;
        #1;
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("in_ready_at_done", 32'(o_in_ready), 32'd1);
        chk("out_valid_at_done", 32'(o_out_valid), 32'd0);
        chk("busy_at_done", 32'(o_busy), 32'd0);
    endtask

    initial begin
        // Reset state, with in_valid high then low.
        next_cycle();
        iv = 1'b1;
        #1;
        chk("rst_load_en_follow", 32'(o_load_en), 32'd1);
        chk("rst_in_ready", 32'(o_in_ready), 32'd1);
        chk("rst_bf_en", 32'(o_bf_en), 32'd0);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        next_cycle();
        iv = 1'b0;
        #1;
        chk("rst_load_en", 32'(o_load_en), 32'd0);
        chk("rst_load_addr", 32'(o_load_addr), 32'd0);
        chk("rst_out_addr", 32'(o_out_addr), 32'd0);
        chk("rst_addr_a", 32'(o_addr_a), 32'd0);
        chk("rst_addr_b", 32'(o_addr_b), 32'd1);
        chk("rst_tw_idx", 32'(o_tw_idx), 32'd0);
        rst = 1'b1;
        next_cycle();

        // Frame 1: back-to-back load, BF_LAT=1 schedule, backpressured drain.
        load_frame(8'hFF);
        check_sched(1);
        drain(3'b001);
        next_cycle();
        chk("done_one_cycle", 32'(o_done), 32'd0);

        // Frame 2: gapped load, identical schedule, full-rate drain.
        load_frame(8'b1011_0101);
        check_sched(1);
        drain(3'b111);

        // Frame 3: reset in the middle of CALC.
        next_cycle();
        load_frame(8'hFF);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            iv = 1'b1;
            #1;
            chk("pre_rst_bf_en", 32'(o_bf_en), 32'd1);
        end
        iv = 1'b0;
        rst = 1'b0;
        next_cycle();
        #1;
        chk("mid_rst_bf_en", 32'(o_bf_en), 32'd0);
        chk("mid_rst_in_ready", 32'(o_in_ready), 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        #1;
        chk("post_rst_in_ready", 32'(o_in_ready), 32'd1);
        chk("post_rst_busy", 32'(o_busy), 32'd0);
        chk("post_rst_bf_en", 32'(o_bf_en), 32'd0);
        chk("post_rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("post_rst_load_addr", 32'(o_load_addr), 32'd0);
        chk("post_rst_addr_a", 32'(o_addr_a), 32'd0);

        // BF_LAT=0 instance: 12 back-to-back butterflies, drain at T+13.
        next_cycle();
        sel0 = 1'b1;
        load_frame(8'hFF);
        check_sched(0);
        drain(3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
